// File: rtl/acc_exec_unit.sv
// Accumulator execution unit with a three-state FSM.
// LOAD/ADD/SUB take one EXEC cycle; MUL uses WIDTH-cycle shift-add.
module acc_exec_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       opc,
    input  logic [WIDTH-1:0] operand,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_MUL} op_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    state_e             state, state_nxt;
    op_e                op_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH:0]     mul_upper;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res_lo, res_hi;
    logic               res_c, res_v;
    logic               accept, exec_last;

    assign accept    = (state == S_IDLE) && start;
    assign exec_last = (op_q != OP_MUL) || (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_EXEC;
            S_EXEC:  if (exec_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One shift-add step: multiplier sits in the low half, shifted out LSB first
    always_comb begin
        mul_upper = {1'b0, prod[2*WIDTH-1:WIDTH]}
                  + (prod[0] ? {1'b0, acc} : (WIDTH+1)'(0));
        prod_nxt  = {mul_upper, prod[WIDTH-1:1]};
    end

    // Result and flag selection for the operation being retired
    always_comb begin
        b_eff  = (op_q == OP_SUB) ? ~b_q : b_q;
        sum    = {1'b0, acc} + {1'b0, b_eff} + (WIDTH+1)'(op_q == OP_SUB);
        res_lo = sum[WIDTH-1:0];
        res_hi = '0;
        res_c  = sum[WIDTH];
        res_v  = (acc[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
        case (op_q)
            OP_LOAD: begin
                res_lo = b_q;
                res_c  = 1'b0;
                res_v  = 1'b0;
            end
            OP_MUL: begin
                res_lo = prod_nxt[WIDTH-1:0];
                res_hi = prod_nxt[2*WIDTH-1:WIDTH];
                res_c  = |prod_nxt[2*WIDTH-1:WIDTH];
                res_v  = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs; architectural state only changes on the retiring edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ready  <= 1'b1;
            done   <= 1'b0;
            acc    <= '0;
            acc_hi <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            op_q   <= OP_LOAD;
            b_q    <= '0;
            cnt    <= '0;
            prod   <= '0;
        end else begin
            ready <= (state_nxt == S_IDLE);
            done  <= (state_nxt == S_DONE);
            if (accept) begin
                op_q <= op_e'(opc);
                b_q  <= operand;
                cnt  <= '0;
                prod <= {WIDTH'(0), operand};
            end
            if (state == S_EXEC) begin
                if (op_q == OP_MUL) begin
                    prod <= prod_nxt;
                    cnt  <= cnt + CNT_W'(1);
                end
                if (exec_last) begin
                    acc    <= res_lo;
                    acc_hi <= res_hi;
                    flag_c <= res_c;
                    flag_z <= (res_lo == '0);
                    flag_n <= res_lo[WIDTH-1];
                    flag_v <= res_v;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_exec_unit.sv
// Bench for acc_exec_unit: directed and random operations against an
// integer-arithmetic reference model.
module tb_acc_exec_unit;

    localparam int unsigned W   = 8;
    localparam int          MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   opc;
    logic [W-1:0] operand;
    logic         ready;
    logic         done;
    logic [W-1:0] acc;
    logic [W-1:0] acc_hi;
    logic         flag_c, flag_z, flag_n, flag_v;

    int n_checks = 0;
    int n_pass   = 0;

    int m_acc = 0, m_hi = 0, m_c = 0, m_z = 0, m_n = 0, m_v = 0;

    acc_exec_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opc     (opc),
        .operand (operand),
        .ready   (ready),
        .done    (done),
        .acc     (acc),
        .acc_hi  (acc_hi),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_v  (flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input int x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    // Reference: plain integer arithmetic on the architectural values
    function automatic void model(input int op, input int b);
        int a;
        int r;
        a = m_acc;
        case (op)
            0: begin m_acc = b; m_hi = 0; m_c = 0; m_v = 0; end
            1: begin
                m_acc = (a + b) % MOD; m_hi = 0; m_c = int'((a + b) >= MOD);
                r = sx(a) + sx(b); m_v = int'(r > MOD / 2 - 1 || r < -(MOD / 2));
            end
            2: begin
                m_acc = (a - b + MOD) % MOD; m_hi = 0; m_c = int'(a >= b);
                r = sx(a) - sx(b); m_v = int'(r > MOD / 2 - 1 || r < -(MOD / 2));
            end
            default: begin
                m_acc = (a * b) % MOD; m_hi = (a * b) / MOD;
                m_c = int'(m_hi != 0); m_v = 0;
            end
        endcase
        m_z = int'(m_acc == 0);
        m_n = int'(m_acc >= MOD / 2);
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    endfunction

    task automatic check_arch(input string tag);
        chk({tag, "_acc"}, 32'(acc), 32'(m_acc));
        chk({tag, "_acc_hi"}, 32'(acc_hi), 32'(m_hi));
        chk({tag, "_flags"}, {28'd0, flag_c, flag_z, flag_n, flag_v},
            32'((m_c << 3) | (m_z << 2) | (m_n << 1) | m_v));
    endtask

    // Issue one op from idle; spam keeps start high with junk while busy
    task automatic run_op(input int op, input int b, input bit spam);
        int lat_exp;
        int held_acc;
        int edges;
        lat_exp  = (op == 3) ? int'(W) : 1;
        held_acc = m_acc;
        edges    = 0;
        chk("ready_idle", 32'(ready), 32'd1);
        start   = 1'b1;
        opc     = 2'(op);
        operand = W'(b);
        step();
        model(op, b);
        while (done !== 1'b1 && edges < 40) begin
            chk("ready_busy", 32'(ready), 32'd0);
            chk("acc_hold", 32'(acc), 32'(held_acc));
            start   = spam;
            opc     = 2'($urandom);
            operand = W'($urandom);
            step();
            edges++;
        end
        chk("latency", 32'(edges), 32'(lat_exp));
        chk("ready_done", 32'(ready), 32'd0);
        check_arch("result");
        start   = spam;
        opc     = 2'($urandom);
        operand = W'($urandom);
        step();
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
        chk("acc_after", 32'(acc), 32'(m_acc));
    endtask

    int dir_op[13] = '{0, 2, 0, 1, 1, 0, 1, 0, 2, 0, 2, 0, 3};
    int dir_b [13] = '{8'h04, 8'h03, 8'h0D, 8'h0A, 8'hF0, 8'h7F, 8'h01,
                       8'h03, 8'h03, 8'h00, 8'h01, 8'h0F, 8'h11};

    initial begin
        bit done_seen;
        rst = 1'b1; start = 1'b0; opc = 2'd0; operand = '0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        check_arch("rst");

        // Directed sequences
        for (int i = 0; i < 13; i++) begin
            run_op(dir_op[i], dir_b[i], 1'b0);
        end
        chk("mul_0f_11", {16'd0, acc_hi, acc}, 32'h00FF);
        run_op(0, 8'hFF, 1'b0);
        run_op(3, 8'hFF, 1'b0);
        chk("mul_ff_ff", {16'd0, acc_hi, acc}, 32'hFE01);
        chk("mul_ff_carry", 32'(flag_c), 32'd1);

        // start held high with varying opc/operand through MUL and DONE
        run_op(0, 8'h21, 1'b0);
        run_op(3, 8'h05, 1'b1);
        chk("mul_21_05", {16'd0, acc_hi, acc}, 32'h00A5);

        // Random ops
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)),
                   1'($urandom));
        end

        // Reset during the 4th MUL EXEC cycle
        run_op(0, 8'h33, 1'b0);
        start = 1'b1; opc = 2'd3; operand = 8'h07;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("abort_ready", 32'(ready), 32'd1);
        check_arch("abort");
        done_seen = 1'b0;
        repeat (W + 2) begin
            done_seen |= done;
            step();
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        check_arch("abort_later");

        // Reset wins over a simultaneous start
        start = 1'b1; opc = 2'd0; operand = 8'h5A; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst_start_ready", 32'(ready), 32'd1);
        step();
        chk("rst_start_done", 32'(done), 32'd0);
        check_arch("rst_start");

        run_op(0, 8'h80, 1'b0);
        run_op(2, 8'h01, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_exec_unit.md
ACC_EXEC_UNIT -- requirements
Module: acc_exec_unit

Interface
REQ-001: Parameter WIDTH, default 8, datapath width of accumulator and operand.
REQ-002: clk  input  1  rising-edge clock, sole clock domain.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: start  input  1  request; accepted on a rising edge when start=1 and ready=1.
REQ-005: opc  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 MUL; sampled only at accept.
REQ-006: operand  input  WIDTH  B operand; sampled only at accept.
REQ-007: ready  output  1  high when idle and able to accept.
REQ-008: done  output  1  one-cycle pulse marking a valid updated result.
REQ-009: acc  output  WIDTH  accumulator, low byte of result.
REQ-010: acc_hi  output  WIDTH  high byte of MUL product; cleared by LOAD/ADD/SUB.
REQ-011: flag_c, flag_z, flag_n, flag_v  outputs  1 each  carry, zero, negative, signed overflow.

Function
REQ-012: The block SHALL be a three-state FSM: IDLE, EXEC, DONE.
REQ-013: IDLE: ready=1; on accept SHALL latch opc and operand, go to EXEC.
REQ-014: EXEC with LOAD/ADD/SUB: one cycle; SHALL write result and flags on the edge leaving EXEC, go to DONE.
REQ-015: EXEC with MUL: exactly WIDTH cycles of shift-add (unsigned, one multiplier bit per cycle, LSB first); product written on the last EXEC edge, go to DONE.
REQ-016: DONE: done=1, ready=0 for exactly one cycle, then IDLE; done is 0 in every other state.
REQ-017: Latency accept-edge to done-high: 2 cycles for LOAD/ADD/SUB, WIDTH+1 cycles for MUL.
REQ-018: start while ready=0 SHALL be ignored (not queued); opc/operand changes after accept SHALL not affect the result.
REQ-019: LOAD: acc=operand, acc_hi=0, flag_c=0, flag_v=0.
REQ-020: ADD: {flag_c,acc}=acc+operand (WIDTH+1-bit sum), acc_hi=0.
REQ-021: SUB: acc=acc+~operand+1; flag_c=carry-out of that sum (1 = no borrow, acc>=operand unsigned); acc_hi=0.
REQ-022: flag_v for ADD/SUB SHALL be set when operand signs (after inversion for SUB) match and result sign differs.
REQ-023: MUL: {acc_hi,acc}=acc*operand unsigned; flag_c=(acc_hi!=0); flag_v=0.
REQ-024: flag_z SHALL be (acc==0) and flag_n SHALL be acc[WIDTH-1], for every op (MUL uses low byte only).
REQ-025: acc, acc_hi and flags SHALL hold their values between operations and during MUL EXEC cycles (intermediate partial products kept in internal registers only).
REQ-026: Wrap-around: ADD/SUB results SHALL be modulo 2^WIDTH with no saturation.
REQ-027: A start asserted in the DONE cycle SHALL be ignored; back-to-back accepts are spaced at least 3 cycles (ALU) or WIDTH+2 cycles (MUL).

Reset
REQ-028: rst=1 at a rising edge SHALL force IDLE, acc=0, acc_hi=0, all flags 0, done=0, ready=1, in any state.
REQ-029: rst during MUL EXEC SHALL abort; no partial product SHALL reach acc/acc_hi.
REQ-030: rst SHALL take priority over a simultaneous start; that start is dropped.

Verification
REQ-031: rst, then LOAD 0x04, then SUB 0x03 -> acc=0x01, flag_c=1, flag_z=0, done high 2 cycles after each accept.
REQ-032: LOAD 0x0D, ADD 0x0A -> acc=0x17, flag_c=0, flag_v=0; then ADD 0xF0 -> acc=0x07, flag_c=1.
REQ-033: LOAD 0x7F, ADD 0x01 -> acc=0x80, flag_v=1, flag_n=1; LOAD 0x03, SUB 0x03 -> acc=0x00, flag_z=1, flag_c=1; LOAD 0x00, SUB 0x01 -> acc=0xFF, flag_c=0.
REQ-034: LOAD 0x0F, MUL 0x11 -> acc=0xFF, acc_hi=0x00, flag_c=0, done exactly 9 cycles after accept; LOAD 0xFF, MUL 0xFF -> {acc_hi,acc}=0xFE01, flag_c=1.
REQ-035: start held high continuously with varying opc/operand during MUL -> only first request executed, ready=0 throughout EXEC/DONE.
REQ-036: rst asserted at 4th MUL EXEC cycle -> next cycle acc=0, acc_hi=0, ready=1, no done pulse.
